// File: rtl/fft_frame_packer.sv
// Buffers ADC I/Q samples and emits fixed-length FFT frames on an AXI4-Stream master.
// A frame only starts once a full frame is buffered, so it never starves mid-frame.
module fft_frame_packer #(
    parameter int BIT_NUM       = 24,
    parameter int DEPTH_LOG2    = 11,
    parameter int NFFT_MAX_LOG2 = 10
) (
    input  logic                   SYS_CLK,
    input  logic                   SYS_RST,
    input  logic                   CFG_ENABLE,
    input  logic                   CFG_MODE,
    input  logic [3:0]             CFG_NFFT_LOG2,
    input  logic [7:0]             CFG_NUM_FRAMES,
    input  logic [BIT_NUM-1:0]     I_DATA_IN,
    input  logic [BIT_NUM-1:0]     Q_DATA_IN,
    input  logic                   DATA_IN_VALID,
    output logic [2*BIT_NUM-1:0]   M_TDATA,
    output logic                   M_TVALID,
    output logic                   M_TLAST,
    input  logic                   M_TREADY,
    output logic [DEPTH_LOG2:0]    FILL_COUNT,
    output logic [7:0]             FRAME_CNT,
    output logic                   OVERFLOW,
    output logic                   BUSY
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DW    = 2 * BIT_NUM;
    localparam int LW    = NFFT_MAX_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic [3:0] clamp_nfft(input logic [3:0] v);
        logic [3:0] r;
        if (v < 4'd3) begin
            r = 4'd3;
        end else if (v > 4'(NFFT_MAX_LOG2)) begin
            r = 4'(NFFT_MAX_LOG2);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [DW-1:0]         mem [DEPTH];
    logic [DW-1:0]         mem_q_r;
    logic                  rd_vld_r;
    logic                  rd_last_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   fill_r;
    logic                  overflow_r;

    state_t                state_r;
    logic [LW-1:0]         len_r;
    logic [LW-1:0]         issue_cnt_r;
    logic                  cnt_clear_r;
    logic [7:0]            frame_cnt_r;
    logic                  busy_r;

    logic [DW-1:0]         tdata_r;
    logic                  tvalid_r;
    logic                  tlast_r;
    logic [DW-1:0]         skid_data_r;
    logic                  skid_last_r;
    logic                  skid_vld_r;

    logic                  full_s;
    logic                  wr_en_s;
    logic                  pop_s;
    logic [1:0]            occ_s;
    logic                  room_s;
    logic                  rd_en_s;
    logic                  rd_last_s;
    logic [LW-1:0]         len_cfg_s;
    logic [7:0]            frame_inc_s;
    logic [7:0]            num_eff_s;
    logic                  len_ready_s;

    // Datapath control: write gating, read issue credit and frame bookkeeping.
    always_comb begin
        full_s      = (fill_r == FILL_FULL);
        wr_en_s     = DATA_IN_VALID && !full_s;
        pop_s       = tvalid_r && M_TREADY;
        occ_s       = {1'b0, tvalid_r} + {1'b0, skid_vld_r} + {1'b0, rd_vld_r};
        // Reads in flight plus held beats never exceed the two output slots.
        room_s      = (occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s);
        rd_en_s     = (state_r == ST_STREAM) && (issue_cnt_r != len_r)
                      && (fill_r != '0) && room_s;
        rd_last_s   = (issue_cnt_r == (len_r - LW'(1'b1)));
        len_cfg_s   = LW'(1'b1) << clamp_nfft(CFG_NFFT_LOG2);
        frame_inc_s = (frame_cnt_r == 8'hFF) ? 8'hFF : (frame_cnt_r + 8'd1);
        num_eff_s   = (CFG_NUM_FRAMES == 8'd0) ? 8'd1 : CFG_NUM_FRAMES;
        len_ready_s = (fill_r >= {{(DEPTH_LOG2+1-LW){1'b0}}, len_r});
    end

    // Sample RAM: one write port, one registered read port.
    always_ff @(posedge SYS_CLK) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= {Q_DATA_IN, I_DATA_IN};
        end
        if (rd_en_s) begin
            mem_q_r <= mem[rd_ptr_r];
        end
    end

    // Pointers, exact fill level and sticky overflow.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fill_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1'b1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   fill_r <= fill_r + (DEPTH_LOG2+1)'(1'b1);
                2'b01:   fill_r <= fill_r - (DEPTH_LOG2+1)'(1'b1);
                default: fill_r <= fill_r;
            endcase
            if (DATA_IN_VALID && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Frame sequencing FSM.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_r     <= ST_IDLE;
            len_r       <= LW'(8);
            issue_cnt_r <= '0;
            cnt_clear_r <= 1'b1;
            frame_cnt_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (CFG_ENABLE) begin
                        state_r     <= ST_WAIT;
                        busy_r      <= 1'b1;
                        len_r       <= len_cfg_s;
                        cnt_clear_r <= 1'b0;
                        if (cnt_clear_r) begin
                            frame_cnt_r <= 8'd0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!CFG_ENABLE) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (len_ready_s) begin
                        state_r     <= ST_STREAM;
                        issue_cnt_r <= '0;
                    end
                end
                ST_STREAM: begin
                    if (rd_en_s) begin
                        issue_cnt_r <= issue_cnt_r + LW'(1'b1);
                    end
                    if (pop_s && tlast_r) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    frame_cnt_r <= frame_inc_s;
                    if (CFG_MODE && (frame_inc_s >= num_eff_s)) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // The count restarts only when the next burst is armed.
                    if (!CFG_ENABLE) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        cnt_clear_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read return stage feeding a two-entry output queue (head plus skid).
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            rd_vld_r    <= 1'b0;
            rd_last_r   <= 1'b0;
            tdata_r     <= '0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            skid_data_r <= '0;
            skid_last_r <= 1'b0;
            skid_vld_r  <= 1'b0;
        end else begin
            rd_vld_r  <= rd_en_s;
            rd_last_r <= rd_en_s && rd_last_s;
            if (tvalid_r && !pop_s) begin
                if (rd_vld_r) begin
                    skid_data_r <= mem_q_r;
                    skid_last_r <= rd_last_r;
                    skid_vld_r  <= 1'b1;
                end
            end else if (skid_vld_r) begin
                tdata_r     <= skid_data_r;
                tlast_r     <= skid_last_r;
                tvalid_r    <= 1'b1;
                skid_data_r <= mem_q_r;
                skid_last_r <= rd_last_r;
                skid_vld_r  <= rd_vld_r;
            end else begin
                tvalid_r <= rd_vld_r;
                tlast_r  <= rd_vld_r && rd_last_r;
                if (rd_vld_r) begin
                    tdata_r <= mem_q_r;
                end
            end
        end
    end

    assign M_TDATA    = tdata_r;
    assign M_TVALID   = tvalid_r;
    assign M_TLAST    = tlast_r;
    assign FILL_COUNT = fill_r;
    assign FRAME_CNT  = frame_cnt_r;
    assign OVERFLOW   = overflow_r;
    assign BUSY       = busy_r;

endmodule
